raster_edge_sequencer: RTL and testbench

- Controller that time-shares one edge_function instance across a triangle-setup step and per-pixel barycentric evaluation.
- Per triangle it latches v0/v1/v2 and computes area = edge(v0,v1,v2) once.
- Per pixel p it issues w0=edge(v1,v2,p), w1=edge(v2,v0,p) and w2=edge(v0,v1,p) back-to-back, then emits the three weights and an inside flag.
- It sits between the triangle/pixel walker and the float edge datapath.

---
 rtl/raster_pkg.sv | 34 +++
 rtl/op_timeout_counter.sv | 30 +++
 rtl/raster_edge_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_raster_edge_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/raster_pkg.sv
// Shared types and helpers for the raster edge sequencing blocks.
// Float32 sign tests only; no arithmetic lives here.
package raster_pkg;

  localparam int FP_SIGN_BIT = 31;
  localparam int FP_MAG_MSB  = 30;

  // [0] = x, [1] = y, each a float32
  typedef logic [1:0][31:0] vec2_t;

  typedef enum logic [3:0] {
    IDLE,
    AREA_REQ,
    AREA_WAIT,
    READY,
    E0_REQ,
    E0_WAIT,
    E1_REQ,
    E1_WAIT,
    E2_REQ,
    E2_WAIT,
    RESULT,
    FAULT
  } state_t;

  function automatic logic fp_is_nonneg(
    input logic [31:0] w,
    input logic        zero_ok
  );
    return !w[FP_SIGN_BIT] ||
           (zero_ok && (w[FP_MAG_MSB:0] == '0));
  endfunction

endpackage

// File: rtl/op_timeout_counter.sv
// Per-operation watchdog: cleared before an operation, counts its
// wait cycles and flags the last permitted one.
module op_timeout_counter #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  assign expired_o = enable_i && (cnt == LAST);

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (enable_i && !expired_o) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/raster_edge_sequencer.sv
// Time-shares one external edge_function across triangle setup
// (area) and the three per-pixel barycentric weights.
module raster_edge_sequencer
  import raster_pkg::*;
#(
  parameter int TIMEOUT     = 1023,
  parameter bit ZERO_INSIDE = 1'b1
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic        tri_valid_i,
  output logic        tri_ready_o,
  input  vec2_t       v0_i,
  input  vec2_t       v1_i,
  input  vec2_t       v2_i,
  output logic [31:0] area_o,
  output logic        degenerate_o,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  input  vec2_t       p_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic [31:0] w0_o,
  output logic [31:0] w1_o,
  output logic [31:0] w2_o,
  output logic        inside_o,
  output logic        error_o,
  output vec2_t       ef_a_o,
  output vec2_t       ef_b_o,
  output vec2_t       ef_c_o,
  output logic        ef_exec_strobe_o,
  input  logic [31:0] ef_z_i,
  input  logic        ef_done_strobe_i
);

  state_t state, state_d;
  vec2_t  v0_q, v1_q, v2_q, p_q;
  vec2_t  a_d, b_d, c_d;
  logic   ld_ops;
  logic   tri_acc, pix_acc;
  logic   in_req, in_wait;
  logic   expired;

  assign in_req = state inside
    {AREA_REQ, E0_REQ, E1_REQ, E2_REQ};
  assign in_wait = state inside
    {AREA_WAIT, E0_WAIT, E1_WAIT, E2_WAIT};

  // Readies drop while reset is held, not only after it releases.
  assign tri_ready_o = !reset_i &&
    ((state == IDLE) || (state == READY));
  assign pix_ready_o = !reset_i &&
    (state == READY) && !tri_valid_i;

  assign tri_acc = tri_valid_i && tri_ready_o;
  assign pix_acc = pix_valid_i && pix_ready_o;

  assign res_valid_o = (state == RESULT);
  assign inside_o = res_valid_o && !degenerate_o &&
    fp_is_nonneg(w0_o, ZERO_INSIDE) &&
    fp_is_nonneg(w1_o, ZERO_INSIDE) &&
    fp_is_nonneg(w2_o, ZERO_INSIDE);

  op_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .reset_i  (reset_i),
    .clear_i  (in_req),
    .enable_i (in_wait),
    .expired_o(expired)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    ld_ops  = 1'b0;
    a_d     = ef_a_o;
    b_d     = ef_b_o;
    c_d     = ef_c_o;
    unique case (state)
      IDLE, READY: begin
        if (tri_acc) begin
          state_d = AREA_REQ;
          ld_ops  = 1'b1;
          a_d     = v0_i;
          b_d     = v1_i;
          c_d     = v2_i;
        end else if (pix_acc) begin
          state_d = E0_REQ;
          ld_ops  = 1'b1;
          a_d     = v1_q;
          b_d     = v2_q;
          c_d     = p_i;
        end
      end
      AREA_REQ: state_d = AREA_WAIT;
      E0_REQ:   state_d = E0_WAIT;
      E1_REQ:   state_d = E1_WAIT;
      E2_REQ:   state_d = E2_WAIT;
      AREA_WAIT: begin
        if (ef_done_strobe_i) state_d = READY;
        else if (expired)     state_d = FAULT;
      end
      E0_WAIT: begin
        if (ef_done_strobe_i) begin
          state_d = E1_REQ;
          ld_ops  = 1'b1;
          a_d     = v2_q;
          b_d     = v0_q;
          c_d     = p_q;
        end else if (expired) begin
          state_d = FAULT;
        end
      end
      E1_WAIT: begin
        if (ef_done_strobe_i) begin
          state_d = E2_REQ;
          ld_ops  = 1'b1;
          a_d     = v0_q;
          b_d     = v1_q;
          c_d     = p_q;
        end else if (expired) begin
          state_d = FAULT;
        end
      end
      E2_WAIT: begin
        if (ef_done_strobe_i) state_d = RESULT;
        else if (expired)     state_d = FAULT;
      end
      RESULT: begin
        if (res_ready_i) state_d = READY;
      end
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      v0_q             <= '0;
      v1_q             <= '0;
      v2_q             <= '0;
      p_q              <= '0;
      area_o           <= '0;
      degenerate_o     <= 1'b0;
      w0_o             <= '0;
      w1_o             <= '0;
      w2_o             <= '0;
      error_o          <= 1'b0;
      ef_a_o           <= '0;
      ef_b_o           <= '0;
      ef_c_o           <= '0;
      ef_exec_strobe_o <= 1'b0;
    end else begin
      ef_exec_strobe_o <= in_req;
      if (ld_ops) begin
        ef_a_o <= a_d;
        ef_b_o <= b_d;
        ef_c_o <= c_d;
      end
      if (tri_acc) begin
        v0_q <= v0_i;
        v1_q <= v1_i;
        v2_q <= v2_i;
      end
      if (pix_acc) p_q <= p_i;
      if (in_wait && !ef_done_strobe_i && expired) error_o <= 1'b1;
      if (ef_done_strobe_i) begin
        unique case (1'b1)
          state == AREA_WAIT: begin
            area_o       <= ef_z_i;
            degenerate_o <= ef_z_i[FP_SIGN_BIT] ||
                            (ef_z_i[FP_MAG_MSB:0] == '0);
          end
          state == E0_WAIT: w0_o <= ef_z_i;
          state == E1_WAIT: w1_o <= ef_z_i;
          state == E2_WAIT: w2_o <= ef_z_i;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_raster_edge_sequencer.sv
// Randomised bench for raster_edge_sequencer with a behavioural
// edge_function responder and an integer-arithmetic coverage model.
module tb_raster_edge_sequencer;
  import raster_pkg::*;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        tri_valid_i, pix_valid_i, res_ready_i;
  vec2_t       v0, v1, v2, p;
  logic        tri_ready_o, pix_ready_o, res_valid_o;
  logic [31:0] area_o, w0_o, w1_o, w2_o;
  logic        degenerate_o, inside_o, error_o;
  vec2_t       ef_a_o, ef_b_o, ef_c_o;
  logic        ef_exec_strobe_o;
  logic [31:0] ef_z;
  logic        ef_done;

  always #5 clk = ~clk;

  raster_edge_sequencer #(.TIMEOUT(15), .ZERO_INSIDE(1'b1)) dut (
    .clk(clk), .reset_i(reset_i),
    .tri_valid_i(tri_valid_i), .tri_ready_o(tri_ready_o),
    .v0_i(v0), .v1_i(v1), .v2_i(v2),
    .area_o(area_o), .degenerate_o(degenerate_o),
    .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o), .p_i(p),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .w0_o(w0_o), .w1_o(w1_o), .w2_o(w2_o), .inside_o(inside_o),
    .error_o(error_o),
    .ef_a_o(ef_a_o), .ef_b_o(ef_b_o), .ef_c_o(ef_c_o),
    .ef_exec_strobe_o(ef_exec_strobe_o),
    .ef_z_i(ef_z), .ef_done_strobe_i(ef_done)
  );

  int vectors = 0;
  int miss = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] i2f(input int v, input bit negz);
    logic [31:0] m, t;
    int e;
    if (v == 0) return negz ? 32'h8000_0000 : 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    e = 0;
    for (int i = 0; i < 31; i++) if (m[i]) e = i;
    t = m << (23 - e);
    return {(v < 0), 8'(127 + e), t[22:0]};
  endfunction

  function automatic int f2i(input logic [31:0] f);
    int e;
    logic [31:0] mant, mag;
    if (f[30:0] == 31'd0) return 0;
    e = int'(f[30:23]) - 127;
    mant = {8'd0, 1'b1, f[22:0]};
    mag = mant >> (23 - e);
    return f[31] ? -int'(mag) : int'(mag);
  endfunction

  // edge(a,b,c) = (c-a) x (b-a); zero results come back as +0 or -0
  // depending on operand bits, so both encodings get exercised.
  function automatic logic [31:0] ef_ref(input vec2_t a, input vec2_t b,
                                         input vec2_t c);
    int r;
    r = (f2i(c[0]) - f2i(a[0])) * (f2i(b[1]) - f2i(a[1])) -
        (f2i(c[1]) - f2i(a[1])) * (f2i(b[0]) - f2i(a[0]));
    return i2f(r, a[0][23] ^ c[1][24] ^ b[1][25]);
  endfunction

  function automatic vec2_t pt(input int x, input int y);
    vec2_t r;
    r[0] = i2f(x, 1'b0);
    r[1] = i2f(y, 1'b0);
    return r;
  endfunction

  function automatic vec2_t rpt();
    return pt(int'($urandom_range(0, 12)) - 4,
              int'($urandom_range(0, 12)) - 4);
  endfunction

  // ---------------- edge_function responder ----------------
  int ef_limit = 1 << 30;
  int ef_answered = 0;
  int exec_cnt = 0;
  int last_done_cyc = -10;
  int stray_req = 0;
  int stray_served = 0;

  initial begin
    vec2_t a, b, c;
    int lat;
    ef_done = 1'b0;
    ef_z = '0;
    forever begin
      @(negedge clk);
      if (stray_req != stray_served) begin
        stray_served++;
        @(posedge clk); #1;
        ef_z = 32'h4100_0000;
        ef_done = 1'b1;
        @(posedge clk); #1;
        ef_done = 1'b0;
      end else if (ef_exec_strobe_o && !reset_i) begin
        exec_cnt++;
        if (ef_answered < ef_limit) begin
          ef_answered++;
          a = ef_a_o; b = ef_b_o; c = ef_c_o;
          lat = int'($urandom_range(0, 3));
          repeat (lat + 1) @(posedge clk);
          #1;
          chk("ef_a_stable", ef_a_o, a);
          chk("ef_b_stable", ef_b_o, b);
          chk("ef_c_stable", ef_c_o, c);
          ef_z = ef_ref(a, b, c);
          ef_done = 1'b1;
          last_done_cyc = cyc;
          @(posedge clk); #1;
          ef_done = 1'b0;
        end
      end
    end
  end

  // ---------------- result sink ----------------
  int rr_mode = 1;
  initial begin
    res_ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       res_ready_i = ($urandom_range(0, 9) < 7);
        1:       res_ready_i = 1'b1;
        default: res_ready_i = 1'b0;
      endcase
    end
  end

  // ---------------- model + compare ----------------
  typedef struct {
    logic [31:0] w0, w1, w2;
    logic        in;
  } res_t;

  res_t  q[$];
  vec2_t mv0, mv1, mv2;
  logic [31:0] m_area = '0;
  logic  m_deg = 1'b0;
  logic  prev_exec = 1'b0;
  logic  prev_rv = 1'b0;

  always @(negedge clk) begin
    res_t r;
    int w0i, w1i, w2i;
    if (reset_i) begin
      q.delete();
      m_area = '0;
      m_deg = 1'b0;
      prev_exec = 1'b0;
      prev_rv = 1'b0;
    end else begin
      if (ef_exec_strobe_o) chk("exec_one_cycle", prev_exec, 0);
      if (tri_ready_o) begin
        chk("area", area_o, m_area);
        chk("degenerate", degenerate_o, m_deg);
      end
      if (tri_valid_i) chk("pix_ready_vs_tri", pix_ready_o, 0);
      if (res_valid_o) begin
        chk("readies_in_result", {tri_ready_o, pix_ready_o}, 0);
        if (!prev_rv) chk("latency", cyc, last_done_cyc + 1);
        if (q.size() == 0) begin
          chk("unexpected_result", res_valid_o, 0);
        end else begin
          chk("w0", w0_o, q[0].w0);
          chk("w1", w1_o, q[0].w1);
          chk("w2", w2_o, q[0].w2);
          chk("inside", inside_o, q[0].in);
          if (res_ready_i) void'(q.pop_front());
        end
      end
      if (tri_valid_i && tri_ready_o) begin
        mv0 = v0; mv1 = v1; mv2 = v2;
        m_area = ef_ref(v0, v1, v2);
        m_deg = (f2i(m_area) <= 0);
      end
      if (pix_valid_i && pix_ready_o) begin
        r.w0 = ef_ref(mv1, mv2, p);
        r.w1 = ef_ref(mv2, mv0, p);
        r.w2 = ef_ref(mv0, mv1, p);
        w0i = f2i(r.w0); w1i = f2i(r.w1); w2i = f2i(r.w2);
        r.in = !m_deg && w0i >= 0 && w1i >= 0 && w2i >= 0;
        q.push_back(r);
      end
      prev_exec = ef_exec_strobe_o;
      prev_rv = res_valid_o;
    end
  end

  // ---------------- drivers ----------------
  task automatic send_tri(input vec2_t a, input vec2_t b, input vec2_t c);
    int n;
    @(posedge clk); #1;
    v0 = a; v1 = b; v2 = c;
    tri_valid_i = 1'b1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tri_ready_o) break;
    end
    if (n == 300) chk("tri_accept_timeout", 1, 0);
    @(posedge clk); #1;
    tri_valid_i = 1'b0;
  endtask

  task automatic send_pix(input vec2_t a);
    int n;
    @(posedge clk); #1;
    p = a;
    pix_valid_i = 1'b1;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (pix_ready_o) break;
    end
    if (n == 300) chk("pix_accept_timeout", 1, 0);
    @(posedge clk); #1;
    pix_valid_i = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (res_valid_o) break;
    end
    if (n == 300) chk("result_timeout", 1, 0);
  endtask

  task automatic wait_tri_ready();
    int n;
    for (n = 0; n < 300; n++) begin
      @(negedge clk);
      if (tri_ready_o) break;
    end
    if (n == 300) chk("setup_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
  endtask

  initial begin
    int base, t0, n;
    logic [31:0] hold;
    reset_i = 1'b1;
    tri_valid_i = 1'b0;
    pix_valid_i = 1'b0;
    v0 = '0; v1 = '0; v2 = '0; p = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tri_ready", tri_ready_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_exec", ef_exec_strobe_o, 0);
    chk("rst_area", area_o, 0);
    chk("rst_ef_a", ef_a_o, 0);
    reset_i = 1'b0;
    @(negedge clk);
    chk("idle_tri_ready", tri_ready_o, 1);

    base = exec_cnt;
    send_tri(pt(0, 0), pt(0, 4), pt(4, 0));
    wait_tri_ready();
    chk("area_lit", area_o, 32'h4180_0000);
    chk("area_deg_lit", degenerate_o, 0);
    chk("area_exec_count", exec_cnt - base, 1);

    send_pix(pt(1, 1));
    wait_res();
    chk("in_w0_lit", w0_o, 32'h4100_0000);
    chk("in_w1_lit", w1_o, 32'h4080_0000);
    chk("in_w2_lit", w2_o, 32'h4080_0000);
    chk("in_inside_lit", inside_o, 1);

    send_pix(pt(5, 5));
    wait_res();
    chk("out_w0_lit", w0_o, 32'hC1C0_0000);
    chk("out_inside_lit", inside_o, 0);

    rr_mode = 2;
    send_pix(pt(2, 1));
    wait_res();
    hold = w0_o;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", res_valid_o, 1);
      chk("bp_w0_hold", w0_o, hold);
      chk("bp_pix_ready", pix_ready_o, 0);
    end
    rr_mode = 1;
    wait_tri_ready();

    @(posedge clk); #1;
    v0 = pt(0, 0); v1 = pt(0, 8); v2 = pt(8, 0); p = pt(1, 1);
    tri_valid_i = 1'b1;
    pix_valid_i = 1'b1;
    @(negedge clk);
    chk("prio_tri_ready", tri_ready_o, 1);
    chk("prio_pix_ready", pix_ready_o, 0);
    @(posedge clk); #1;
    tri_valid_i = 1'b0;
    pix_valid_i = 1'b0;
    wait_tri_ready();
    chk("prio_area_lit", area_o, 32'h4280_0000);
    chk("prio_no_result", res_valid_o, 0);

    send_tri(pt(1, 1), pt(1, 1), pt(1, 1));
    wait_tri_ready();
    chk("deg_lit", degenerate_o, 1);
    chk("deg_area_mag", {33'd0, area_o[30:0]}, 0);
    send_pix(pt(3, 2));
    wait_res();
    chk("deg_inside_lit", inside_o, 0);

    rr_mode = 0;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) send_tri(rpt(), rpt(), rpt());
      else send_pix(rpt());
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rr_mode = 1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !res_valid_o && tri_ready_o) break;
    end
    if (n == 500) chk("drain_timeout", 1, 0);

    // watchdog: datapath never answers
    pulse_reset();
    ef_limit = ef_answered;
    send_tri(pt(0, 0), pt(0, 4), pt(4, 0));
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ef_exec_strobe_o) break;
    end
    t0 = cyc;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (error_o) break;
    end
    chk("timeout_cycles", cyc - t0, 15);
    @(posedge clk); #1;
    tri_valid_i = 1'b1;
    pix_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("fault_tri_ready", tri_ready_o, 0);
      chk("fault_pix_ready", pix_ready_o, 0);
      chk("fault_error", error_o, 1);
    end
    @(posedge clk); #1;
    tri_valid_i = 1'b0;
    pix_valid_i = 1'b0;
    #2 reset_i = 1'b1;
    #1 chk("async_err_clear", error_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("post_fault_idle", tri_ready_o, 1);

    // reset while stuck in the second weight's wait
    ef_limit = ef_answered + 2;
    base = exec_cnt;
    send_tri(pt(0, 0), pt(0, 4), pt(4, 0));
    send_pix(pt(1, 1));
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (exec_cnt - base >= 3) break;
    end
    chk("reach_e1_wait", exec_cnt - base, 3);
    repeat (3) @(posedge clk);
    #3 reset_i = 1'b1;
    #1;
    chk("mid_rst_ef_a", ef_a_o, 0);
    chk("mid_rst_w0", w0_o, 0);
    chk("mid_rst_res_valid", res_valid_o, 0);
    @(posedge clk); #1;
    reset_i = 1'b0;
    ef_limit = 1 << 30;
    stray_req++;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stray_idle", tri_ready_o, 1);
      chk("stray_no_result", res_valid_o, 0);
      chk("stray_area", area_o, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule
